// File: rtl/column_pkg.sv
// column_pkg
// Shared word-size constants and the sequencer state type for the bit-serial
// column and the activation sequencer that feeds it.
// Contents:
//   WORDLEN, LOG2_WORDLEN  activation/weight word length and its log2
//   NROWS, LOG2_NROWS      rows per column and its log2
//   seq_state_e            sequencer FSM states
package column_pkg;

    localparam int WORDLEN      = 8;
    localparam int LOG2_WORDLEN = 3;
    localparam int NROWS        = 64;
    localparam int LOG2_NROWS   = 6;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } seq_state_e;

endpackage

// File: rtl/seq_delay_line.sv
// seq_delay_line
// Fixed-depth shift register carrying the {valid, last, bit index} tag of each
// streamed bit, so the column controls line up with the column's own pipeline.
// Ports:
//   clock, resetn            clock and async active-low reset
//   in_valid/in_last/in_idx  tag entering the line
//   out_valid/out_last/out_idx tag leaving the line DEPTH cycles later
//   any_valid                some stage holds a valid tag
module seq_delay_line
    import column_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IDX_W = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic             out_last,
    output logic [IDX_W-1:0] out_idx,
    output logic             any_valid
);

    localparam int TAG_W = IDX_W + 2;

    logic [DEPTH-1:0][TAG_W-1:0] stage_q;
    logic [DEPTH-1:0][TAG_W-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = {in_valid, in_last, in_idx};
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage_q[i][TAG_W-1];
        end
    end

    assign {out_valid, out_last, out_idx} = stage_q[DEPTH-1];

endmodule

// File: rtl/activation_sequencer.sv
// activation_sequencer
// Accepts an activation vector (one word per row) and streams it LSB first as
// one bit per row per cycle into a bit-serial column, together with the
// accumulator shift amount, accumulator clear and final-sum strobe aligned to
// the column's two-cycle latency. Back-to-back vectors stream with no bubble.
// Ports:
//   clock, resetn  clock and async active-low reset
//   act_valid/act  offered activation vector (NROWS x WORDLEN, unsigned)
//   act_ready      vector is accepted this cycle
//   ia             bit-serial activation bits, one per row
//   shift          bit index of the sum now leaving the column tree
//   acc_clear      column accumulator loads instead of accumulating
//   sum_valid      column sum is final this cycle
//   busy           a vector is streaming or still in the column pipeline
//
// state  | meaning
// IDLE   | nothing streaming, ready for a vector
// STREAM | driving bit bitcnt of the held vector; ready again on the last bit
module activation_sequencer #(
    parameter int WORDLEN      = column_pkg::WORDLEN,
    parameter int LOG2_WORDLEN = column_pkg::LOG2_WORDLEN,
    parameter int NROWS        = column_pkg::NROWS
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            act_valid,
    input  logic [NROWS-1:0][WORDLEN-1:0]   act,
    output logic                            act_ready,
    output logic [NROWS-1:0]                ia,
    output logic [WORDLEN-1:0]              shift,
    output logic                            acc_clear,
    output logic                            sum_valid,
    output logic                            busy
);

    import column_pkg::*;

    localparam logic [LOG2_WORDLEN-1:0] BIT_LAST = LOG2_WORDLEN'(WORDLEN - 1);

    seq_state_e                    state_q, state_d;
    logic [LOG2_WORDLEN-1:0]       bitcnt_q, bitcnt_d;
    logic [NROWS-1:0][WORDLEN-1:0] hold_q, hold_d;
    logic [NROWS-1:0]              ia_q, ia_d;
    logic                          tag_valid_q, tag_valid_d;
    logic                          tag_last_q, tag_last_d;
    logic [LOG2_WORDLEN-1:0]       tag_idx_q, tag_idx_d;
    logic                          sum_valid_q, sum_valid_d;

    logic                          transfer;
    logic                          streaming;
    logic                          dl_valid;
    logic                          dl_last;
    logic [LOG2_WORDLEN-1:0]       dl_idx;
    logic                          dl_any;

    assign streaming = (state_q == STREAM);
    assign act_ready = (state_q == IDLE) || (streaming && (bitcnt_q == BIT_LAST));
    assign transfer  = act_valid && act_ready;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        hold_d   = hold_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d  = STREAM;
                    bitcnt_d = '0;
                end
            end
            STREAM: begin
                if (bitcnt_q == BIT_LAST) begin
                    // A vector accepted on the last bit streams next cycle with no bubble.
                    bitcnt_d = '0;
                    state_d  = transfer ? STREAM : IDLE;
                end else begin
                    bitcnt_d = bitcnt_q + LOG2_WORDLEN'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                bitcnt_d = '0;
            end
        endcase
        if (transfer) begin
            hold_d = act;
        end
    end

    // The ia register is the first column pipeline stage; the tag register
    // travels alongside it so the delay line only has to cover the tree stage
    // and the accumulator-input stage.
    always_comb begin
        ia_d        = '0;
        tag_valid_d = streaming;
        tag_last_d  = streaming && (bitcnt_q == BIT_LAST);
        tag_idx_d   = streaming ? bitcnt_q : '0;
        if (streaming) begin
            for (int r = 0; r < NROWS; r++) begin
                ia_d[r] = hold_q[r][bitcnt_q];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            hold_q      <= '0;
            ia_q        <= '0;
            tag_valid_q <= 1'b0;
            tag_last_q  <= 1'b0;
            tag_idx_q   <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            hold_q      <= hold_d;
            ia_q        <= ia_d;
            tag_valid_q <= tag_valid_d;
            tag_last_q  <= tag_last_d;
            tag_idx_q   <= tag_idx_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    seq_delay_line #(
        .DEPTH (2),
        .IDX_W (LOG2_WORDLEN)
    ) u_delay (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (tag_valid_q),
        .in_last   (tag_last_q),
        .in_idx    (tag_idx_q),
        .out_valid (dl_valid),
        .out_last  (dl_last),
        .out_idx   (dl_idx),
        .any_valid (dl_any)
    );

    // The accumulator absorbs the last bit in the cycle after its shift, so the
    // sum is final one cycle later.
    assign sum_valid_d = dl_valid && dl_last;

    assign ia        = ia_q;
    assign shift     = dl_valid ? WORDLEN'(dl_idx) : '0;
    assign acc_clear = dl_valid && (dl_idx == '0);
    assign sum_valid = sum_valid_q;
    assign busy      = streaming || tag_valid_q || dl_any || sum_valid_q;

endmodule

// File: tb/tb_activation_sequencer.sv
module tb_activation_sequencer;

    localparam int WL = 8;
    localparam int NR = 64;

    typedef logic [NR-1:0][WL-1:0] vec_t;

    logic             clock;
    logic             resetn;
    logic             act_valid;
    vec_t             act;
    logic             act_ready;
    logic [NR-1:0]    ia;
    logic [WL-1:0]    shift;
    logic             acc_clear;
    logic             sum_valid;
    logic             busy;

    int checks = 0;
    int errors = 0;

    activation_sequencer #(
        .WORDLEN      (WL),
        .LOG2_WORDLEN (3),
        .NROWS        (NR)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .act_valid (act_valid),
        .act       (act),
        .act_ready (act_ready),
        .ia        (ia),
        .shift     (shift),
        .acc_clear (acc_clear),
        .sum_valid (sum_valid),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " ia"}, 64'(ia), 64'd0);
        chk({tag, " shift"}, 64'(shift), 64'd0);
        chk({tag, " acc_clear"}, 64'(acc_clear), 64'd0);
        chk({tag, " sum_valid"}, 64'(sum_valid), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
    endtask

    // Expected outputs in cycle c<n> after the first transfer, for nvec
    // vectors accepted back to back (a first, b second).
    task automatic check_cycle(input string name, input int n, input int nvec,
                               input vec_t a, input vec_t b);
        logic [63:0] e_ia;
        int          e_shift;
        bit          e_clr, e_sv, e_busy, e_rdy;
        vec_t        v;
        int          j, k, m;
        string       tag;
        e_ia = '0;
        if (n >= 1 && (n - 1) < 8 * nvec) begin
            j = (n - 1) / 8;
            k = (n - 1) % 8;
            v = (j == 0) ? a : b;
            for (int r = 0; r < NR; r++) e_ia[r] = v[r][k];
        end
        m       = n - 3;
        e_shift = 0;
        e_clr   = 1'b0;
        if (m >= 0 && m < 8 * nvec) begin
            e_shift = m % 8;
            e_clr   = ((m % 8) == 0);
        end
        e_sv   = (n >= 11) && (((n - 11) % 8) == 0) && (((n - 11) / 8) < nvec);
        e_busy = (n <= 8 * nvec + 3);
        e_rdy  = (n >= 8 * nvec) || ((n % 8) == 7);
        tag = $sformatf("%s c%0d", name, n);
        chk({tag, " ia"}, 64'(ia), e_ia);
        chk({tag, " shift"}, 64'(shift), 64'(e_shift));
        chk({tag, " acc_clear"}, 64'(acc_clear), 64'(e_clr));
        chk({tag, " sum_valid"}, 64'(sum_valid), 64'(e_sv));
        chk({tag, " busy"}, 64'(busy), 64'(e_busy));
        chk({tag, " act_ready"}, 64'(act_ready), 64'(e_rdy));
    endtask

    vec_t v_ff, v_five, v_a, v_b, v_c, v_junk, v_zero;

    initial begin
        v_zero = '0;
        for (int r = 0; r < NR; r++) begin
            v_ff[r]   = 8'hFF;
            v_five[r] = 8'h00;
            v_a[r]    = 8'(r * 37 + 11);
            v_b[r]    = 8'(r * 113 + 90);
            v_c[r]    = 8'(r * 71 + 201);
            v_junk[r] = 8'(r * 5 + 170);
        end
        v_five[0] = 8'h05;

        // Reset state
        resetn    = 1'b0;
        act_valid = 1'b0;
        act       = '0;
        #12;
        chk_quiet("reset");
        resetn = 1'b1;
        #1;
        chk("reset_release act_ready", 64'(act_ready), 64'd1);

        // Idle with act_valid low for 20 cycles
        for (int n = 0; n < 20; n++) begin
            step();
            chk_quiet($sformatf("idle%0d", n));
        end

        // All-ones vector
        act       = v_ff;
        act_valid = 1'b1;
        step();
        act_valid = 1'b0;
        for (int n = 0; n <= 13; n++) begin
            check_cycle("ones", n, 1, v_ff, v_zero);
            step();
        end

        // Single row 8'h05
        act       = v_five;
        act_valid = 1'b1;
        step();
        act_valid = 1'b0;
        act       = v_junk;
        for (int n = 0; n <= 12; n++) begin
            check_cycle("row0_05", n, 1, v_five, v_zero);
            step();
        end

        // Two vectors with act_valid held high
        act       = v_a;
        act_valid = 1'b1;
        step();
        act = v_b;
        for (int n = 0; n <= 21; n++) begin
            check_cycle("b2b", n, 2, v_a, v_b);
            if (n == 8) act_valid = 1'b0;
            step();
        end

        // Valid raised mid-stream waits for the last bit
        act       = v_a;
        act_valid = 1'b1;
        step();
        act_valid = 1'b0;
        act       = v_junk;
        for (int n = 0; n <= 21; n++) begin
            check_cycle("midvalid", n, 2, v_a, v_c);
            if (n == 3) begin
                act       = v_c;
                act_valid = 1'b1;
                #1;
                chk("midvalid c3 act_ready_held_off", 64'(act_ready), 64'd0);
            end
            if (n == 8) act_valid = 1'b0;
            step();
        end

        // Reset in the middle of a stream
        act       = v_ff;
        act_valid = 1'b1;
        step();
        act_valid = 1'b0;
        for (int n = 0; n <= 3; n++) begin
            check_cycle("abort", n, 1, v_ff, v_zero);
            step();
        end
        check_cycle("abort", 4, 1, v_ff, v_zero);
        #1;
        resetn = 1'b0;
        #1;
        chk_quiet("abort_in_reset");
        #2;
        resetn = 1'b1;
        #1;
        chk("abort_release act_ready", 64'(act_ready), 64'd1);
        for (int n = 0; n < 12; n++) begin
            step();
            chk_quiet($sformatf("abort_after%0d", n));
            chk($sformatf("abort_after%0d act_ready", n), 64'(act_ready), 64'd1);
        end

        act       = v_ff;
        act_valid = 1'b1;
        step();
        act_valid = 1'b0;
        for (int n = 0; n <= 13; n++) begin
            check_cycle("post_abort", n, 1, v_ff, v_zero);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/activation_sequencer.md
ACTIVATION_SEQUENCER -- requirements
Module: activation_sequencer

Interface
REQ-001 SHALL have parameter WORDLEN, default 8: activation and weight word length in bits.
REQ-002 SHALL have parameter LOG2_WORDLEN, default 3: log2(WORDLEN).
REQ-003 SHALL have parameter NROWS, default 64: number of column rows, one activation per row.
REQ-004 SHALL have port clock, input, 1: the single clock; all state changes on posedge.
REQ-005 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port act_valid, input, 1: an activation vector is offered.
REQ-007 SHALL have port act, input, NROWS x WORDLEN, unsigned: the activation vector, one word per row.
REQ-008 SHALL have port act_ready, output, 1: the sequencer accepts act this cycle.
REQ-009 SHALL have port ia, output, NROWS: bit-serial activation bits to the column.
REQ-010 SHALL have port shift, output, WORDLEN: accumulator shift amount, an integer bit index.
REQ-011 SHALL have port acc_clear, output, 1: the column accumulator loads shifted instead of accum+shifted.
REQ-012 SHALL have port sum_valid, output, 1: the column sum is final this cycle.
REQ-013 SHALL have port busy, output, 1: a vector is streaming or its shift/valid pipeline is non-empty.

Function
REQ-014 SHALL implement an FSM with states IDLE and STREAM, plus bit counter bitcnt[LOG2_WORDLEN-1:0].
REQ-015 Transfer SHALL occur on a posedge with act_valid && act_ready; act is captured into a holding register.
REQ-016 SHALL drive act_ready = (state==IDLE) || (state==STREAM && bitcnt==WORDLEN-1).
REQ-017 IDLE: on transfer -> STREAM with bitcnt=0; otherwise stay.
REQ-018 STREAM: bitcnt increments each cycle.
REQ-019 STREAM at bitcnt==WORDLEN-1: on transfer, bitcnt wraps to 0 and new data loads with no bubble; otherwise -> IDLE.
REQ-020 Registered output: with transfer at edge E0, ia[r] SHALL equal act[r][k] during cycle c(1+k), k=0..WORDLEN-1, LSB first.
REQ-021 ia SHALL be all-zero whenever no bit is streaming.
REQ-022 Column latency is 2 cycles (ia register, treesum register), so shift SHALL equal k during cycle c(3+k), i.e. bit index delayed exactly 2 cycles behind its ia bit.
REQ-023 shift SHALL be 0 when no bit is in flight.
REQ-024 acc_clear SHALL be high for exactly one cycle per vector, in c3 (coincident with shift=0 of that vector).
REQ-025 sum_valid SHALL pulse for one cycle in c(WORDLEN+3) per vector.
REQ-026 Back-to-back vectors: sum_valid of vector n SHALL coincide with acc_clear of vector n+1 (the column accum is still old in that cycle).
REQ-027 act SHALL be sampled only at transfer; changes on act outside transfer SHALL have no effect.
REQ-028 act_valid while act_ready is low SHALL NOT be accepted; the producer holds it.
REQ-029 No arithmetic is performed; shift SHALL be zero-extended from LOG2_WORDLEN to WORDLEN bits.

Reset
REQ-030 On resetn low, asynchronously: state=IDLE, bitcnt=0, holding register and delay pipeline cleared, ia=0, shift=0, acc_clear=0, sum_valid=0, busy=0.
REQ-031 After reset release, act_ready SHALL be 1 in the first cycle.
REQ-032 Reset mid-stream SHALL abort the vector with no sum_valid; the column shares resetn and clears with it.

Structure
REQ-033 WORDLEN, LOG2_WORDLEN, NROWS, LOG2_NROWS and the state enum SHALL live in shared package column_pkg, used by both column and sequencer.
REQ-034 The 2-stage {valid, last, bit index} delay SHALL be a sub-module seq_delay_line (parameter DEPTH=2), async active-low reset.

Verification
REQ-035 All act words 8'hFF, weights all 1, one transfer -> ia all-ones c1..c8, shift 0..7 in c3..c10, acc_clear in c3, sum_valid in c11, column sum = 64*255 = 16320.
REQ-036 act[0]=8'h05, all other rows 0 -> ia[0] = 1,0,1,0,0,0,0,0 over c1..c8; other ia bits 0.
REQ-037 Two vectors with act_valid held high -> second accepted at bitcnt=7, ia continuous for 16 cycles, sum_valid(1) and acc_clear(2) both in c11, sum_valid(2) in c19.
REQ-038 act_valid asserted at bitcnt=3 of a stream -> act_ready=0 and no capture; accepted at bitcnt=7.
REQ-039 resetn pulsed low during c4 -> all outputs 0 immediately, no sum_valid; act_ready=1 after release; the next vector behaves per REQ-035.
REQ-040 act_valid held 0 for 20 cycles after reset -> ia=0, shift=0, sum_valid=0, busy=0 throughout.
